// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD raster path.
// Contents: rgb_t pixel type, sync_t sideband bundle, default 640x480@60
// timing, RGB888 colour constants and the colour-bar lookup.
package lcd_pkg;

    typedef logic [23:0] rgb_t;

    // Sideband bundle carried through the sync delay line; all active-high.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } sync_t;

    localparam int unsigned LCD_H_DISP  = 640;
    localparam int unsigned LCD_H_FRONT = 16;
    localparam int unsigned LCD_H_SYNC  = 96;
    localparam int unsigned LCD_H_BACK  = 48;
    localparam int unsigned LCD_V_DISP  = 480;
    localparam int unsigned LCD_V_FRONT = 10;
    localparam int unsigned LCD_V_SYNC  = 2;
    localparam int unsigned LCD_V_BACK  = 33;

    localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
    localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
    localparam rgb_t RGB_CYAN    = 24'h00FFFF;
    localparam rgb_t RGB_GREEN   = 24'h00FF00;
    localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
    localparam rgb_t RGB_RED     = 24'hFF0000;
    localparam rgb_t RGB_BLUE    = 24'h0000FF;
    localparam rgb_t RGB_BLACK   = 24'h000000;

    // Colour of bar idx, left to right.
    function automatic rgb_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_sync_delay.sv
// Fixed-depth shift register with synchronous clear.
// Ports: clk, rst (sync, active-high), din[WIDTH], dout[WIDTH] = din delayed DEPTH cycles.
module lcd_sync_delay #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Clear flushes every stage so nothing stale drains out after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/lcd_timing_driver.sv
// Raster timing generator and pixel output stage for the VGA/LCD path.
// Ports:
//   clk, rst (sync, active-high)
//   lcd_data    : pixel returned by the display stage, DATA_LATENCY after coords
//   lcd_xpos/ypos, lcd_request : coordinate request, one cycle ahead of H_START
//   lcd_hs/vs (active low), lcd_de, lcd_rgb, frame_start : panel-aligned outputs
// Build option: define LCD_COLORBAR_EN to replace lcd_data with eight vertical
// colour bars; left undefined, only the pass-through path exists.
module lcd_timing_driver
    import lcd_pkg::*;
#(
    parameter int unsigned H_DISP       = LCD_H_DISP,
    parameter int unsigned H_FRONT      = LCD_H_FRONT,
    parameter int unsigned H_SYNC       = LCD_H_SYNC,
    parameter int unsigned H_BACK       = LCD_H_BACK,
    parameter int unsigned V_DISP       = LCD_V_DISP,
    parameter int unsigned V_FRONT      = LCD_V_FRONT,
    parameter int unsigned V_SYNC       = LCD_V_SYNC,
    parameter int unsigned V_BACK       = LCD_V_BACK,
    parameter int unsigned DATA_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  rgb_t        lcd_data,
    output logic [11:0] lcd_xpos,
    output logic [11:0] lcd_ypos,
    output logic        lcd_request,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output rgb_t        lcd_rgb,
    output logic        frame_start
);

    localparam int unsigned CNT_W    = 12;
    localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned H_START  = H_SYNC + H_BACK;
    localparam int unsigned REQ_H_LO = H_START - 1;
    localparam int unsigned REQ_H_HI = H_START + H_DISP - 1;
    localparam int unsigned V_START  = V_SYNC + V_BACK;
    localparam int unsigned V_END    = V_START + V_DISP;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap_c;
    logic             req_c;
    sync_t            sync_raw_c;
    sync_t            sync_dly;
    rgb_t             pix_c;

    assign h_wrap_c = (h_cnt == CNT_W'(H_TOTAL - 1));

    // Raster counters: line count advances on the pixel-count wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap_c) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // Request window opens one clock early so the registered coords land on H_START.
    assign req_c = (h_cnt >= CNT_W'(REQ_H_LO)) && (h_cnt < CNT_W'(REQ_H_HI)) &&
                   (v_cnt >= CNT_W'(V_START))  && (v_cnt < CNT_W'(V_END));

    // Stage 0: coordinate request to the display stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_request <= 1'b0;
            lcd_xpos    <= '0;
            lcd_ypos    <= '0;
        end else begin
            lcd_request <= req_c;
            lcd_xpos    <= req_c ? h_cnt - CNT_W'(REQ_H_LO) : '0;
            lcd_ypos    <= req_c ? v_cnt - CNT_W'(V_START) : '0;
        end
    end

    always_comb begin
        sync_raw_c    = '0;
        sync_raw_c.hs = (h_cnt < CNT_W'(H_SYNC));
        sync_raw_c.vs = (v_cnt < CNT_W'(V_SYNC));
        sync_raw_c.de = req_c;
        sync_raw_c.fs = (h_cnt == '0) && (v_cnt == '0);
    end

    // Stage 0 plus display-stage latency; the output register adds the last cycle.
    lcd_sync_delay #(
        .DEPTH (DATA_LATENCY + 1),
        .WIDTH ($bits(sync_t))
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (sync_raw_c),
        .dout (sync_dly)
    );

`ifdef LCD_COLORBAR_EN
    localparam int unsigned BAR_W = H_DISP / 8;

    logic [CNT_W-1:0] bar_q_c;
    logic [2:0]       bar_idx_c;
    logic [2:0]       bar_dly;
    logic             unused_data;

    // Bar index follows the requested column, clamped for any remainder pixels.
    assign bar_q_c   = lcd_xpos / CNT_W'(BAR_W);
    assign bar_idx_c = (bar_q_c > CNT_W'(7)) ? 3'd7 : bar_q_c[2:0];

    // Match the display stage's latency so bars align exactly like real data.
    lcd_sync_delay #(
        .DEPTH (DATA_LATENCY),
        .WIDTH (3)
    ) u_bar_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (bar_idx_c),
        .dout (bar_dly)
    );

    assign pix_c       = bar_color(bar_dly);
    assign unused_data = ^lcd_data;
`else
    assign pix_c = lcd_data;
`endif

    // Output register: sync back to active-low, colour blanked outside DE.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_hs      <= 1'b1;
            lcd_vs      <= 1'b1;
            lcd_de      <= 1'b0;
            frame_start <= 1'b0;
            lcd_rgb     <= '0;
        end else begin
            lcd_hs      <= ~sync_dly.hs;
            lcd_vs      <= ~sync_dly.vs;
            lcd_de      <= sync_dly.de;
            frame_start <= sync_dly.fs;
            lcd_rgb     <= sync_dly.de ? pix_c : '0;
        end
    end

endmodule

// File: tb/tb_lcd_timing_driver.sv
module tb_lcd_timing_driver;

    // Reduced raster for whole-frame checks; the full 640x480 instance covers line-level checks.
    localparam int SH_S = 4;
    localparam int SH_B = 3;
    localparam int SH_D = 16;
    localparam int SH_F = 2;
    localparam int SV_S = 2;
    localparam int SV_B = 2;
    localparam int SV_D = 6;
    localparam int SV_F = 1;

`ifdef LCD_COLORBAR_EN
    localparam logic [23:0] PX_0    = 24'hFFFFFF;
    localparam logic [23:0] PX_80   = 24'hFFFF00;
    localparam logic [23:0] PX_300  = 24'h00FF00;
    localparam logic [23:0] PX_399  = 24'hFF00FF;
    localparam logic [23:0] PX_639  = 24'h000000;
    localparam logic [23:0] PX_SLST = 24'h000000;
`else
    localparam logic [23:0] PX_0    = 24'h00005A;
    localparam logic [23:0] PX_80   = 24'h50005A;
    localparam logic [23:0] PX_300  = 24'h2C005A;
    localparam logic [23:0] PX_399  = 24'h8F005A;
    localparam logic [23:0] PX_639  = 24'h7F005A;
    localparam logic [23:0] PX_SLST = 24'h0F055A;
`endif

    logic        clk;
    logic        rst;
    logic [23:0] b_data, b_rgb, s1_data, s1_rgb, s3_data, s3_rgb;
    logic [23:0] s3_p1, s3_p2;
    logic [11:0] b_xpos, b_ypos, s1_xpos, s1_ypos, s3_xpos, s3_ypos;
    logic        b_req, b_hs, b_vs, b_de, b_fs;
    logic        s1_req, s1_hs, s1_vs, s1_de, s1_fs;
    logic        s3_req, s3_hs, s3_vs, s3_de, s3_fs;

    int    total;
    int    bad;
    int    k;
    int    sb_err;
    string sb_note;

    lcd_timing_driver #(.DATA_LATENCY(1)) u_big (
        .clk(clk), .rst(rst), .lcd_data(b_data), .lcd_xpos(b_xpos), .lcd_ypos(b_ypos),
        .lcd_request(b_req), .lcd_hs(b_hs), .lcd_vs(b_vs), .lcd_de(b_de),
        .lcd_rgb(b_rgb), .frame_start(b_fs)
    );

    lcd_timing_driver #(
        .H_DISP(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_DISP(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .DATA_LATENCY(1)
    ) u_s1 (
        .clk(clk), .rst(rst), .lcd_data(s1_data), .lcd_xpos(s1_xpos), .lcd_ypos(s1_ypos),
        .lcd_request(s1_req), .lcd_hs(s1_hs), .lcd_vs(s1_vs), .lcd_de(s1_de),
        .lcd_rgb(s1_rgb), .frame_start(s1_fs)
    );

    lcd_timing_driver #(
        .H_DISP(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_DISP(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .DATA_LATENCY(3)
    ) u_s3 (
        .clk(clk), .rst(rst), .lcd_data(s3_data), .lcd_xpos(s3_xpos), .lcd_ypos(s3_ypos),
        .lcd_request(s3_req), .lcd_hs(s3_hs), .lcd_vs(s3_vs), .lcd_de(s3_de),
        .lcd_rgb(s3_rgb), .frame_start(s3_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Display-stage models: 1-cycle for DATA_LATENCY=1, 3-stage for DATA_LATENCY=3.
`ifdef LCD_COLORBAR_EN
    assign b_data  = 24'h123456;
    assign s1_data = 24'h123456;
    assign s3_data = 24'h123456;
    assign s3_p1   = 24'h0;
    assign s3_p2   = {s3_xpos[7:0], s3_ypos[7:0], 8'h5A} ^ {s1_xpos[7:0], s1_ypos[7:0], 8'h00};
`else
    always_ff @(posedge clk) begin
        b_data  <= {b_xpos[7:0], b_ypos[7:0], 8'h5A};
        s1_data <= {s1_xpos[7:0], s1_ypos[7:0], 8'h5A};
        s3_p1   <= {s3_xpos[7:0], s3_ypos[7:0], 8'h5A};
        s3_p2   <= s3_p1;
        s3_data <= s3_p2;
    end
`endif

    function automatic logic [23:0] pix(input int x, input int y, input int hdisp);
`ifdef LCD_COLORBAR_EN
        int i;
        i = x / (hdisp / 8);
        if (i > 7) i = 7;
        case (i)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
`else
        return {8'(x), 8'(y), 8'h5A} ^ {8'h00, 8'h00, 8'(hdisp & 0)};
`endif
    endfunction

    // Expected {hs,vs,de,fs,rgb, req,xpos,ypos} at cycle kk after counters restart at (0,0).
    function automatic logic [52:0] exp_all(input int kk, input int lat,
                                            input int hsw, input int hbp, input int hdp, input int hfp,
                                            input int vsw, input int vbp, input int vdp, input int vfp);
        int ht, vt, n, h, v, hlo, vlo;
        logic win;
        logic [27:0] o;
        logic [24:0] r;
        ht  = hsw + hbp + hdp + hfp;
        vt  = vsw + vbp + vdp + vfp;
        hlo = hsw + hbp - 1;
        vlo = vsw + vbp;
        r = '0;
        n = kk - 1;
        if (n >= 0) begin
            h = n % ht;
            v = (n / ht) % vt;
            win = (h >= hlo) && (h < hlo + hdp) && (v >= vlo) && (v < vlo + vdp);
            if (win) r = {1'b1, 12'(h - hlo), 12'(v - vlo)};
        end
        o = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
        n = kk - lat - 2;
        if (n >= 0) begin
            h = n % ht;
            v = (n / ht) % vt;
            win = (h >= hlo) && (h < hlo + hdp) && (v >= vlo) && (v < vlo + vdp);
            o[27] = !(h < hsw);
            o[26] = !(v < vsw);
            o[25] = win;
            o[24] = (h == 0) && (v == 0);
            o[23:0] = win ? pix(h - hlo, v - vlo, hdp) : 24'h0;
        end
        return {o, r};
    endfunction

    task automatic score();
        logic [52:0] e;
        e = exp_all(k, 1, 96, 48, 640, 16, 2, 33, 480, 10);
        if ({b_hs, b_vs, b_de, b_fs, b_rgb, b_req, b_xpos, b_ypos} !== e) begin
            sb_err++;
            if (sb_err == 1) sb_note = $sformatf("big k=%0d got=%h exp=%h", k,
                {b_hs, b_vs, b_de, b_fs, b_rgb, b_req, b_xpos, b_ypos}, e);
        end
        e = exp_all(k, 1, SH_S, SH_B, SH_D, SH_F, SV_S, SV_B, SV_D, SV_F);
        if ({s1_hs, s1_vs, s1_de, s1_fs, s1_rgb, s1_req, s1_xpos, s1_ypos} !== e) begin
            sb_err++;
            if (sb_err == 1) sb_note = $sformatf("s1 k=%0d got=%h exp=%h", k,
                {s1_hs, s1_vs, s1_de, s1_fs, s1_rgb, s1_req, s1_xpos, s1_ypos}, e);
        end
        e = exp_all(k, 3, SH_S, SH_B, SH_D, SH_F, SV_S, SV_B, SV_D, SV_F);
        if ({s3_hs, s3_vs, s3_de, s3_fs, s3_rgb, s3_req, s3_xpos, s3_ypos} !== e) begin
            sb_err++;
            if (sb_err == 1) sb_note = $sformatf("s3 k=%0d got=%h exp=%h", k,
                {s3_hs, s3_vs, s3_de, s3_fs, s3_rgb, s3_req, s3_xpos, s3_ypos}, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic step();
        tick();
        score();
    endtask

    // Hold rst for n edges; the cycle after release has counters at (0,0).
    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        k = 0;
        score();
    endtask

    task automatic check_sb(input string name);
        total++;
        if (sb_err !== 0) begin
            bad++;
            $display("FAIL %s scoreboard: %0d mismatches (required 0), first %s", name, sb_err, sb_note);
        end
        sb_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({b_hs, b_vs, b_de, b_fs, b_rgb, b_req, b_xpos, b_ypos} !== {4'b1100, 24'h0, 1'b0, 24'h0}) begin
                bad++;
                $display("FAIL reset_big cyc=%0d got=%h required=%h", i,
                         {b_hs, b_vs, b_de, b_fs, b_rgb, b_req, b_xpos, b_ypos}, {4'b1100, 24'h0, 1'b0, 24'h0});
            end
            total++;
            if ({s3_hs, s3_vs, s3_de, s3_fs, s3_rgb, s3_req} !== {4'b1100, 24'h0, 1'b0}) begin
                bad++;
                $display("FAIL reset_s3 cyc=%0d got=%h required=%h", i,
                         {s3_hs, s3_vs, s3_de, s3_fs, s3_rgb, s3_req}, {4'b1100, 24'h0, 1'b0});
            end
        end
        rst = 1'b0;
        k = 0;
        score();
    endtask

    // Sync leaves through stage 0, DATA_LATENCY delay and the output register.
    task automatic test_hs_start();
        int width;
        width = 0;
        while (b_hs !== 1'b0 && k < 20) step();
        total++;
        if (k !== 3) begin
            bad++;
            $display("FAIL hs_first_low cycle=%0d required=3", k);
        end
        while (b_hs === 1'b0 && width < 200) begin
            width++;
            step();
        end
        total++;
        if (width !== 96) begin
            bad++;
            $display("FAIL hs_width got=%0d required=96", width);
        end
        check_sb("hs_start");
    endtask

    task automatic test_small_frames();
        int falls, last_fall, period, low1, fs_cnt, fs_mis, de1, de3, de_rises, guard;
        logic prev_vs, prev_de;
        logic [23:0] px1, px3;
        falls = 0; last_fall = -1; period = 0; low1 = 0; fs_cnt = 0; fs_mis = 0;
        de1 = 0; de3 = 0; de_rises = 0; px1 = 'x; px3 = 'x;
        apply_reset(1);
        prev_vs = s1_vs;
        prev_de = s1_de;
        while (k < 552) begin
            step();
            if (prev_vs && !s1_vs) begin
                falls++;
                if (last_fall >= 0) period = k - last_fall;
                last_fall = k;
            end
            if (!s1_vs && falls == 1) low1++;
            if (s1_fs) begin
                fs_cnt++;
                if (!(prev_vs && !s1_vs)) fs_mis++;
            end
            if (s1_de) de1++;
            if (s3_de) de3++;
            if (s1_de && !prev_de) de_rises++;
            if (k == 249) px1 = s1_rgb;
            if (k == 251) px3 = s3_rgb;
            prev_vs = s1_vs;
            prev_de = s1_de;
        end
        total++;
        if (falls !== 2 || period !== 275) begin
            bad++;
            $display("FAIL vs_period falls=%0d period=%0d required 2/275", falls, period);
        end
        total++;
        if (low1 !== 50) begin
            bad++;
            $display("FAIL vs_low got=%0d required=50", low1);
        end
        total++;
        if (fs_cnt !== 2 || fs_mis !== 0) begin
            bad++;
            $display("FAIL frame_start pulses=%0d misaligned=%0d required 2/0", fs_cnt, fs_mis);
        end
        total++;
        if (de1 !== 192 || de_rises !== 12) begin
            bad++;
            $display("FAIL de_count_s1 cycles=%0d lines=%0d required 192/12", de1, de_rises);
        end
        total++;
        if (de3 !== 192) begin
            bad++;
            $display("FAIL de_count_s3 got=%0d required=192", de3);
        end
        total++;
        if (px1 !== PX_SLST) begin
            bad++;
            $display("FAIL last_px_s1 got=%h required=%h", px1, PX_SLST);
        end
        total++;
        if (px3 !== PX_SLST) begin
            bad++;
            $display("FAIL last_px_s3 got=%h required=%h", px3, PX_SLST);
        end
        // Reset on a line wrap must not let the line counter advance.
        guard = 0;
        while (!((k % 25) == 24 && ((k / 25) % 11) != 10) && guard < 100) begin
            step();
            guard++;
        end
        apply_reset(1);
        repeat (300) step();
        check_sb("small_frames");
    endtask

    task automatic test_big_window();
        int hs_falls, hs_bad, last, req_rise, de_rise, de_line, rgb_out, raw_seen, last_x;
        logic prev_hs, prev_req, prev_de;
        logic [11:0] rx, ry, prev_x;
        logic [23:0] p0, p80, p300, p399, p639;
        hs_falls = 0; hs_bad = 0; last = -1; req_rise = -1; de_rise = -1; de_line = 0;
        rgb_out = 0; raw_seen = 0; last_x = -1; rx = 'x; ry = 'x;
        p0 = 'x; p80 = 'x; p300 = 'x; p399 = 'x; p639 = 'x;
        prev_hs = b_hs; prev_req = b_req; prev_de = b_de; prev_x = b_xpos;
        while (k < 29200) begin
            step();
            if (prev_hs && !b_hs) begin
                if (last >= 0 && (k - last) != 800) hs_bad++;
                hs_falls++;
                last = k;
            end
            if (b_req && !prev_req && req_rise < 0) begin
                req_rise = k;
                rx = b_xpos;
                ry = b_ypos;
            end
            if (!b_req && prev_req && last_x < 0) last_x = int'(prev_x);
            if (b_de && !prev_de && de_rise < 0) de_rise = k;
            if (b_de && k < 28900) de_line++;
            if (!b_de && b_rgb !== 24'h0) rgb_out++;
            if (b_rgb === 24'h123456) raw_seen++;
            if (k == 28146)       p0   = b_rgb;
            if (k == 28146 + 80)  p80  = b_rgb;
            if (k == 28146 + 300) p300 = b_rgb;
            if (k == 28146 + 399) p399 = b_rgb;
            if (k == 28146 + 639) p639 = b_rgb;
            prev_hs = b_hs; prev_req = b_req; prev_de = b_de; prev_x = b_xpos;
        end
        total++;
        if (hs_falls !== 36 || hs_bad !== 0) begin
            bad++;
            $display("FAIL hs_period falls=%0d off_period=%0d required 36/0", hs_falls, hs_bad);
        end
        total++;
        if (req_rise !== 28144 || rx !== 12'd0 || ry !== 12'd0) begin
            bad++;
            $display("FAIL req_rise k=%0d x=%0d y=%0d required 28144/0/0", req_rise, rx, ry);
        end
        total++;
        if (last_x !== 639) begin
            bad++;
            $display("FAIL req_last_x got=%0d required=639", last_x);
        end
        total++;
        if (de_rise !== req_rise + 2) begin
            bad++;
            $display("FAIL de_rise k=%0d required=%0d", de_rise, req_rise + 2);
        end
        total++;
        if (de_line !== 640) begin
            bad++;
            $display("FAIL de_per_line got=%0d required=640", de_line);
        end
        total++;
        if (rgb_out !== 0 || raw_seen !== 0) begin
            bad++;
            $display("FAIL rgb_blank outside_de=%0d raw_data=%0d required 0/0", rgb_out, raw_seen);
        end
        total++;
        if ({p0, p80, p300} !== {PX_0, PX_80, PX_300}) begin
            bad++;
            $display("FAIL px_a got=%h %h %h required=%h %h %h", p0, p80, p300, PX_0, PX_80, PX_300);
        end
        total++;
        if ({p399, p639} !== {PX_399, PX_639}) begin
            bad++;
            $display("FAIL px_b got=%h %h required=%h %h", p399, p639, PX_399, PX_639);
        end
        check_sb("big_window");
    endtask

    // Reset pulse at h_cnt=400 of line 36, inside an active line.
    task automatic test_mid_reset();
        int de_seen, first_low;
        de_seen = 0;
        first_low = -1;
        total++;
        if (b_de !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_de got=%b required=1", b_de);
        end
        apply_reset(1);
        total++;
        if ({b_de, b_rgb, b_hs, b_vs, b_req} !== {1'b0, 24'h0, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset_out got=%h required=%h", {b_de, b_rgb, b_hs, b_vs, b_req},
                     {1'b0, 24'h0, 1'b1, 1'b1, 1'b0});
        end
        while (k < 200) begin
            step();
            if (b_de) de_seen++;
            if (!b_hs && first_low < 0) first_low = k;
        end
        total++;
        if (de_seen !== 0 || first_low !== 3) begin
            bad++;
            $display("FAIL mid_reset_restart de_cycles=%0d hs_first_low=%0d required 0/3", de_seen, first_low);
        end
        while (k < 1700) step();
        check_sb("mid_reset");
    endtask

    initial begin
        total = 0;
        bad = 0;
        k = 0;
        sb_err = 0;
        sb_note = "";
        rst = 1'b1;
        test_reset();
        test_hs_start();
        test_small_frames();
        test_big_window();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
